// File: rtl/irq_tick_pkg.sv
// rtl/irq_tick_pkg.sv - shared channel-state encoding and mode constants for irq_tick_gen
package irq_tick_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chan_state_e;

  localparam logic PERIODIC = 1'b0;
  localparam logic ONESHOT  = 1'b1;

  // Channel-select width; a single channel still gets a 1-bit select
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_chan.sv
// rtl/tick_chan.sv - one tick channel: period register, counter, IDLE/RUN/DONE state, tick and pending
module tick_chan
  import irq_tick_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk_in,
  input  logic         RESET,
  input  logic         enable,
  input  logic         oneshot,
  input  logic         wr,
  input  logic [W-1:0] wr_data,
  input  logic         ack,
  output logic         tick,
  output logic         pending,
  output logic         running
);

  chan_state_e  state;
  logic [W-1:0] period;
  logic [W-1:0] cnt;
  logic [W-1:0] period_m1;

  assign period_m1 = period - W'(1);

  always_ff @(posedge clk_in) begin
    if (!RESET) begin
      state   <= IDLE;
      period  <= '0;
      cnt     <= '0;
      tick    <= 1'b0;
      pending <= 1'b0;
      running <= 1'b0;
    end else begin
      tick    <= 1'b0;
      pending <= pending & ~ack;
      if (wr) period <= wr_data;

      case (state)
        IDLE: begin
          cnt <= '0;
          // The start edge is itself enabled edge 1, so it is counted here
          if (enable && !wr && period != '0) begin
            if (period_m1 == '0) begin
              tick    <= 1'b1;
              pending <= 1'b1;
              if (oneshot == ONESHOT) begin
                state   <= DONE;
                running <= 1'b0;
              end else begin
                state   <= RUN;
                running <= 1'b1;
              end
            end else begin
              cnt     <= W'(1);
              state   <= RUN;
              running <= 1'b1;
            end
          end
        end

        RUN: begin
          if (!enable) begin
            state   <= IDLE;
            cnt     <= '0;
            running <= 1'b0;
          end else if (wr) begin
            cnt <= '0;
            if (wr_data == '0) begin
              state   <= IDLE;
              running <= 1'b0;
            end
          end else if (cnt == period_m1) begin
            cnt     <= '0;
            tick    <= 1'b1;
            pending <= 1'b1;
            if (oneshot == ONESHOT) begin
              state   <= DONE;
              running <= 1'b0;
            end
          end else begin
            cnt <= cnt + W'(1);
          end
        end

        DONE: begin
          cnt <= '0;
          if (!enable) state <= IDLE;
        end

        default: begin
          state   <= IDLE;
          cnt     <= '0;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/irq_tick_gen.sv
// rtl/irq_tick_gen.sv - NCH independent periodic/one-shot tick channels with a masked interrupt
module irq_tick_gen
  import irq_tick_pkg::*;
#(
  parameter  int NCH = 4,
  parameter  int W   = 32,
  localparam int CW  = sel_width(NCH)
) (
  input  logic           clk_in,
  input  logic           RESET,
  input  logic [NCH-1:0] enable,
  input  logic [NCH-1:0] oneshot,
  input  logic           wr_en,
  input  logic [CW-1:0]  wr_ch,
  input  logic [W-1:0]   wr_data,
  input  logic [NCH-1:0] ack,
  input  logic [NCH-1:0] irq_mask,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] pending,
  output logic [NCH-1:0] running,
  output logic           irq_out
);

  logic [NCH-1:0] wr_hit;

  // Out-of-range channel numbers match no channel and are dropped
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign wr_hit[i] = wr_en && (wr_ch == CW'(i));

    tick_chan #(.W(W)) u_chan (
      .clk_in  (clk_in),
      .RESET   (RESET),
      .enable  (enable[i]),
      .oneshot (oneshot[i]),
      .wr      (wr_hit[i]),
      .wr_data (wr_data),
      .ack     (ack[i]),
      .tick    (tick[i]),
      .pending (pending[i]),
      .running (running[i])
    );
  end

  assign irq_out = |(pending & irq_mask);

endmodule
